// File: rtl/sdram_pkg.sv
// Shared definitions for the sdram byte/halfword/word wrapper and its request arbiter.
package sdram_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK
  } arb_state_t;

  // Encodings the wrapper cannot execute: reserved width, or a word on an odd byte address.
  function automatic logic is_bad_access(input logic addr0, input logic [1:0] width);
    return (width == W_BAD) || ((width == W_WORD) && addr0);
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Two requester ports plus the single wrapper request port of the SDRAM arbiter.
interface sdram_arbiter_if #(
  parameter int AW = 25,
  parameter int DW = 32
);
  logic          p0_req,   p1_req;
  logic [AW-1:0] p0_addr,  p1_addr;
  logic          p0_write, p1_write;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [1:0]    p0_width, p1_width;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          p0_ack,   p1_ack;
  logic          p0_err,   p1_err;

  logic          mem_enable;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_width;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  // The arbiter serves the requesters and drives the wrapper.
  modport slave (
    input  p0_req, p0_addr, p0_write, p0_wdata, p0_width,
    input  p1_req, p1_addr, p1_write, p1_wdata, p1_width,
    output p0_rdata, p0_ack, p0_err, p1_rdata, p1_ack, p1_err,
    output mem_enable, mem_addr, mem_write, mem_wdata, mem_width,
    input  mem_rdata, mem_ready
  );

  modport master (
    output p0_req, p0_addr, p0_write, p0_wdata, p0_width,
    output p1_req, p1_addr, p1_write, p1_wdata, p1_width,
    input  p0_rdata, p0_ack, p0_err, p1_rdata, p1_ack, p1_err,
    input  mem_enable, mem_addr, mem_write, mem_wdata, mem_width,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational two-request grant. SDRAM_ARB_RR_EN selects round-robin on ties,
// otherwise port 1 (data) always wins.
module sdram_arb_pick (
`ifdef SDRAM_ARB_RR_EN
  input  logic       last_grant,
`endif
  input  logic [1:0] req,
  output logic       valid,
  output logic       sel
);

  always_comb begin
    valid = |req;
`ifdef SDRAM_ARB_RR_EN
    // On a tie the port that did not win last time goes first.
    if (&req) sel = ~last_grant;
    else      sel = req[1];
`else
    sel = req[1];
`endif
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port request arbiter in front of the sdram wrapper; defining SDRAM_ARB_RR_EN
// switches fixed priority (port 1 wins) to round-robin.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int AW = 25,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus
);

  arb_state_t    state_reg;
  logic          grant_reg;
  logic          gnt_valid;
  logic          gnt_sel;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_write;
  logic [1:0]    sel_width;
`ifdef SDRAM_ARB_RR_EN
  logic          last_grant_reg;
`endif

  sdram_arb_pick u_pick (
`ifdef SDRAM_ARB_RR_EN
    .last_grant (last_grant_reg),
`endif
    .req        ({bus.p1_req, bus.p0_req}),
    .valid      (gnt_valid),
    .sel        (gnt_sel)
  );

  always_comb begin
    sel_addr  = gnt_sel ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt_sel ? bus.p1_wdata : bus.p0_wdata;
    sel_write = gnt_sel ? bus.p1_write : bus.p0_write;
    sel_width = gnt_sel ? bus.p1_width : bus.p0_width;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_grant_reg <= 1'b1;
`endif
      bus.mem_enable <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_write  <= 1'b0;
      bus.mem_wdata  <= '0;
      bus.mem_width  <= '0;
      bus.p0_rdata   <= '0;
      bus.p1_rdata   <= '0;
      bus.p0_ack     <= 1'b0;
      bus.p1_ack     <= 1'b0;
      bus.p0_err     <= 1'b0;
      bus.p1_err     <= 1'b0;
    end else begin
      bus.p0_ack <= 1'b0;
      bus.p1_ack <= 1'b0;
      bus.p0_err <= 1'b0;
      bus.p1_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gnt_valid) begin
            grant_reg     <= gnt_sel;
`ifdef SDRAM_ARB_RR_EN
            last_grant_reg <= gnt_sel;
`endif
            bus.mem_addr  <= sel_addr;
            bus.mem_write <= sel_write;
            bus.mem_wdata <= sel_wdata;
            bus.mem_width <= sel_width;
            // Rejected requests complete immediately without touching the wrapper.
            if (is_bad_access(sel_addr[0], sel_width)) begin
              bus.p0_ack <= ~gnt_sel;
              bus.p1_ack <= gnt_sel;
              bus.p0_err <= ~gnt_sel;
              bus.p1_err <= gnt_sel;
              state_reg  <= ACK;
            end else begin
              bus.mem_enable <= 1'b1;
              state_reg      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            bus.mem_enable <= 1'b0;
            bus.p0_ack     <= ~grant_reg;
            bus.p1_ack     <= grant_reg;
            if (!bus.mem_write) begin
              if (grant_reg) bus.p1_rdata <= bus.mem_rdata;
              else           bus.p0_rdata <= bus.mem_rdata;
            end
            state_reg <= ACK;
          end
        end
        ACK:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
